ddc_mixer_cic: RTL and testbench

- Digital down-converter stage placed directly downstream of the NCO in the ADC SDR datapath.
- Each clken cycle it multiplies one ADC sample by the NCO cos and sin outputs to form complex baseband I/Q.
- It then runs each of I and Q through an N-stage CIC decimator with a runtime-programmable rate R.
- Decimated I/Q with a one-cycle valid strobe feed the FX2LP packing/FIFO logic.

---
 rtl/ddc_pkg.sv | 32 +++
 rtl/cic_decimator.sv | 68 ++++++
 rtl/ddc_mixer_cic.sv | 141 ++++++++++++++
 tb/tb_ddc_mixer_cic.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_pkg.sv
// ddc_pkg: shared definitions for the down-converter mixer/CIC block.
//   - default widths and the derived mixer/accumulator widths
//   - width helpers so instances with other parameters size themselves
//   - R_MIN and clamp_rate(), the lower bound applied to the rate input
package ddc_pkg;

    localparam int ADC_WIDTH_D   = 12;
    localparam int NCO_WIDTH_D   = 12;
    localparam int CIC_STAGES_D  = 3;
    localparam int DECIM_WIDTH_D = 8;
    localparam int OUT_WIDTH_D   = 16;

    function automatic int calc_mix_w(input int adc_w, input int nco_w);
        return adc_w + nco_w;
    endfunction

    function automatic int calc_acc_w(input int adc_w, input int nco_w,
                                      input int stages, input int decim_w);
        return calc_mix_w(adc_w, nco_w) + stages * decim_w;
    endfunction

    localparam int MIX_W = calc_mix_w(ADC_WIDTH_D, NCO_WIDTH_D);
    localparam int ACC_W = calc_acc_w(ADC_WIDTH_D, NCO_WIDTH_D, CIC_STAGES_D, DECIM_WIDTH_D);

    localparam int unsigned R_MIN = 2;

    // Rates 0 and 1 are meaningless for the shared counter; force them to R_MIN.
    function automatic int unsigned clamp_rate(input int unsigned rate);
        return (rate < R_MIN) ? R_MIN : rate;
    endfunction

endpackage

// File: rtl/cic_decimator.sv
// cic_decimator: one channel of the N-stage CIC decimator.
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   i_int_en  advance the integrator cascade with i_mix
//   i_mix     sign-extended mixer product
//   i_snap    capture the last integrator (end of a decimation period)
//   i_dump    run the comb chain on the captured value and update o_data
//   o_data    truncated comb output (top OUT_W bits of the accumulator)
// All arithmetic wraps modulo 2^ACC_W; the comb differences cancel the wrap.
module cic_decimator
    import ddc_pkg::*;
#(
    parameter int STAGES = CIC_STAGES_D,
    parameter int ACC_W  = ddc_pkg::ACC_W,
    parameter int OUT_W  = OUT_WIDTH_D
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_int_en,
    input  logic signed [ACC_W-1:0] i_mix,
    input  logic                    i_snap,
    input  logic                    i_dump,
    output logic signed [OUT_W-1:0] o_data
);

    logic signed [ACC_W-1:0] r_int  [STAGES];
    logic signed [ACC_W-1:0] r_dly  [STAGES];
    logic signed [ACC_W-1:0] r_snap;
    logic signed [ACC_W-1:0] w_comb [STAGES+1];

    always_comb begin
        w_comb[0] = r_snap;
        for (int k = 0; k < STAGES; k++) begin
            w_comb[k+1] = w_comb[k] - r_dly[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_int[k] <= '0;
                r_dly[k] <= '0;
            end
            r_snap <= '0;
            o_data <= '0;
        end else begin
            // Each stage adds the previous stage's registered value (Hogenauer cascade).
            if (i_int_en) begin
                r_int[0] <= r_int[0] + i_mix;
                for (int k = 1; k < STAGES; k++) begin
                    r_int[k] <= r_int[k] + r_int[k-1];
                end
            end
            // Snapshot isolates the comb from integrator updates that
            // continue while the output is being formed.
            if (i_snap) begin
                r_snap <= r_int[STAGES-1];
            end
            if (i_dump) begin
                for (int k = 0; k < STAGES; k++) begin
                    r_dly[k] <= w_comb[k];
                end
                o_data <= w_comb[STAGES][ACC_W-1 -: OUT_W];
            end
        end
    end

endmodule

// File: rtl/ddc_mixer_cic.sv
// ddc_mixer_cic: complex mixer (multiply by e^-jwt) followed by two CIC
// decimators sharing one decimation counter.
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   clken      sample strobe for adc_i / nco_sin_i / nco_cos_i
//   adc_i      ADC sample
//   nco_sin_i  signed NCO sine
//   nco_cos_i  signed NCO cosine
//   decim_i    decimation rate R (0 and 1 behave as 2)
//   i_o, q_o   decimated I/Q
//   out_valid  one-cycle strobe when i_o/q_o update
// Build option: DDC_ADC_OFFSET_BINARY_EN treats adc_i as offset binary
// (MSB inverted before the multiply); otherwise adc_i is two's complement.
// Timing: sample edge -> mixer reg; +1 integrators; +2 counter tick and
// snapshot; +3 comb result on i_o/q_o with out_valid.
module ddc_mixer_cic
    import ddc_pkg::*;
#(
    parameter int ADC_WIDTH   = ADC_WIDTH_D,
    parameter int NCO_WIDTH   = NCO_WIDTH_D,
    parameter int CIC_STAGES  = CIC_STAGES_D,
    parameter int DECIM_WIDTH = DECIM_WIDTH_D,
    parameter int OUT_WIDTH   = OUT_WIDTH_D
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clken,
    input  logic        [ADC_WIDTH-1:0] adc_i,
    input  logic signed [NCO_WIDTH-1:0] nco_sin_i,
    input  logic signed [NCO_WIDTH-1:0] nco_cos_i,
    input  logic      [DECIM_WIDTH-1:0] decim_i,
    output logic signed [OUT_WIDTH-1:0] i_o,
    output logic signed [OUT_WIDTH-1:0] q_o,
    output logic                        out_valid
);

    localparam int LP_MIX_W = calc_mix_w(ADC_WIDTH, NCO_WIDTH);
    localparam int LP_ACC_W = calc_acc_w(ADC_WIDTH, NCO_WIDTH, CIC_STAGES, DECIM_WIDTH);

    logic signed [ADC_WIDTH-1:0]   w_adc;
    logic signed [LP_MIX_W-1:0]    w_prod_i;
    logic signed [LP_MIX_W-1:0]    w_prod_q;
    logic signed [LP_ACC_W-1:0]    w_ext_i;
    logic signed [LP_ACC_W-1:0]    w_ext_q;
    logic signed [LP_ACC_W-1:0]    r_mix_i;
    logic signed [LP_ACC_W-1:0]    r_mix_q;
    logic                          r_v1;
    logic                          r_v2;
    logic        [DECIM_WIDTH-1:0] r_cnt;
    logic        [DECIM_WIDTH-1:0] r_rate;
    logic        [DECIM_WIDTH-1:0] w_rate_clamped;
    logic                          w_tick;
    logic                          r_tick;
    logic                          r_out_valid;

`ifdef DDC_ADC_OFFSET_BINARY_EN
    assign w_adc = {~adc_i[ADC_WIDTH-1], adc_i[ADC_WIDTH-2:0]};
`else
    assign w_adc = adc_i;
`endif

    assign w_prod_i = w_adc * nco_cos_i;
    assign w_prod_q = w_adc * nco_sin_i;
    assign w_ext_i  = LP_ACC_W'(w_prod_i);
    assign w_ext_q  = LP_ACC_W'(w_prod_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mix_i <= '0;
            r_mix_q <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
        end else begin
            r_v1 <= clken;
            r_v2 <= r_v1;
            if (clken) begin
                r_mix_i <= w_ext_i;
                r_mix_q <= -w_ext_q;
            end
        end
    end

    assign w_rate_clamped = DECIM_WIDTH'(clamp_rate(32'(decim_i)));
    assign w_tick         = r_v2 && (r_cnt == r_rate - DECIM_WIDTH'(1));

    // r_rate == 0 only right after reset (clamped rates are >= 2), so it
    // doubles as the "load on reset release" condition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_rate      <= '0;
            r_tick      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_tick      <= w_tick;
            r_out_valid <= r_tick;
            if (r_rate == '0) begin
                r_rate <= w_rate_clamped;
            end
            if (r_v2) begin
                if (w_tick) begin
                    r_cnt  <= '0;
                    r_rate <= w_rate_clamped;
                end else begin
                    r_cnt <= r_cnt + DECIM_WIDTH'(1);
                end
            end
        end
    end

    assign out_valid = r_out_valid;

    cic_decimator #(
        .STAGES (CIC_STAGES),
        .ACC_W  (LP_ACC_W),
        .OUT_W  (OUT_WIDTH)
    ) u_cic_i (
        .i_clk    (clk),
        .i_rst_n  (reset_n),
        .i_int_en (r_v1),
        .i_mix    (r_mix_i),
        .i_snap   (w_tick),
        .i_dump   (r_tick),
        .o_data   (i_o)
    );

    cic_decimator #(
        .STAGES (CIC_STAGES),
        .ACC_W  (LP_ACC_W),
        .OUT_W  (OUT_WIDTH)
    ) u_cic_q (
        .i_clk    (clk),
        .i_rst_n  (reset_n),
        .i_int_en (r_v1),
        .i_mix    (r_mix_q),
        .i_snap   (w_tick),
        .i_dump   (r_tick),
        .o_data   (q_o)
    );

endmodule

// File: tb/tb_ddc_mixer_cic.sv
// tb_ddc_mixer_cic: scoreboard bench for ddc_mixer_cic.
// Stimulus pushes one expected entry per completed decimation period
// (arrival cycle and, in steady state, the I/Q values); the monitor pops
// and compares whenever out_valid is seen.
// Steady-state values: output = floor(mix * R^3 / 2^32).
//   100*2047 = 204700, R=255  -> 790
//   -2048*2047, R=4           -> -1 ; -(-2048*2047), R=4 -> 0
module tb_ddc_mixer_cic;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               clken = 1'b0;
    logic        [11:0] adc_i = '0;
    logic signed [11:0] nco_sin_i = '0;
    logic signed [11:0] nco_cos_i = '0;
    logic        [7:0]  decim_i = '0;
    logic signed [15:0] i_o;
    logic signed [15:0] q_o;
    logic               out_valid;

    ddc_mixer_cic dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .adc_i     (adc_i),
        .nco_sin_i (nco_sin_i),
        .nco_cos_i (nco_cos_i),
        .decim_i   (decim_i),
        .i_o       (i_o),
        .q_o       (q_o),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 exp_cyc;
        logic signed [15:0] ei;
        logic signed [15:0] eq;
        bit                 chk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // model state (stimulus side)
    int                 m_rate = 2;
    int                 m_cnt = 0;
    int                 n_out = 0;
    int                 latch_edge = 0;
    bit                 latch_pend = 1'b0;
    int                 chk_from = 0;
    logic signed [15:0] s_ei = '0;
    logic signed [15:0] s_eq = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clampr(input int r);
        return (r < 2) ? 2 : r;
    endfunction

    function automatic logic [11:0] to_adc(input int v);
        logic [11:0] t;
        t = 12'(v);
`ifdef DDC_ADC_OFFSET_BINARY_EN
        t[11] = ~t[11];
`endif
        return t;
    endfunction

    // monitor
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("out_valid_cycle", cyc, mon_e.exp_cyc);
                if (mon_e.chk) begin
                    check("i_o", i_o, mon_e.ei);
                    check("q_o", q_o, mon_e.eq);
                end
            end
        end
    end

    // Called at a negedge: drives clken for the next edge and models it.
    task automatic step(input bit ce);
        int e;
        clken = ce;
        e = cyc + 1;
        if (latch_pend && e == latch_edge) begin
            m_rate     = clampr(int'(decim_i));
            latch_pend = 1'b0;
        end
        if (ce) begin
            m_cnt++;
            if (m_cnt == m_rate) begin
                m_cnt = 0;
                n_out++;
                sb.push_back('{e + 3, s_ei, s_eq, (chk_from != 0 && n_out >= chk_from)});
                latch_pend = 1'b1;
                latch_edge = e + 2;
            end
        end
        @(negedge clk);
    endtask

    task automatic release_rst(input int decim);
        decim_i    = 8'(decim);
        reset_n    = 1'b1;
        m_rate     = clampr(decim);
        m_cnt      = 0;
        n_out      = 0;
        latch_pend = 1'b0;
    endtask

    task automatic hard_reset();
        clken   = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        clken = 1'b0;
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        decim_i = 8'd255;
        repeat (3) @(negedge clk);
        check("reset_i_o", i_o, 0);
        check("reset_q_o", q_o, 0);
        check("reset_out_valid", out_valid, 0);

        // I only, R=255
        adc_i = to_adc(100); nco_cos_i = 12'sd2047; nco_sin_i = 12'sd0;
        s_ei = 16'sd790; s_eq = 16'sd0; chk_from = 4;
        release_rst(255);
        repeat (6 * 255) step(1'b1);
        drain("drain_i_only");

        // partial period, then asynchronous reset while i_o holds 790
        repeat (100) step(1'b1);
        clken = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_i_o", i_o, 0);
        check("async_rst_q_o", q_o, 0);
        check("async_rst_out_valid", out_valid, 0);
        @(negedge clk);
        @(negedge clk);

        // Q only, R=255; first output timing after reset comes from the model
        adc_i = to_adc(-100); nco_cos_i = 12'sd0; nco_sin_i = 12'sd2047;
        s_ei = 16'sd0; s_eq = 16'sd790; chk_from = 4;
        release_rst(255);
        repeat (6 * 255) step(1'b1);
        drain("drain_q_only");

        // rate change 4 -> 8 mid-period, then clamped rates 0 and 1
        hard_reset();
        adc_i = to_adc(0); nco_cos_i = 12'sd0; nco_sin_i = 12'sd0;
        chk_from = 0;
        release_rst(4);
        repeat (10) step(1'b1);
        decim_i = 8'd8;
        repeat (30) step(1'b1);
        decim_i = 8'd0;
        repeat (20) step(1'b1);
        decim_i = 8'd1;
        repeat (12) step(1'b1);
        drain("drain_rate_change");

        // gated clken, one in three, R=4
        hard_reset();
        adc_i = to_adc(-2048); nco_cos_i = 12'sd2047; nco_sin_i = 12'sd2047;
        s_ei = -16'sd1; s_eq = 16'sd0; chk_from = 4;
        release_rst(4);
        repeat (32) begin
            step(1'b1);
            step(1'b0);
            step(1'b0);
        end
        drain("drain_gated");

        // same samples, continuous clken: same values
        hard_reset();
        release_rst(4);
        repeat (32) step(1'b1);
        drain("drain_continuous");

`ifdef DDC_ADC_OFFSET_BINARY_EN
        // mid-scale offset-binary code is zero signal
        hard_reset();
        adc_i = 12'h800; nco_cos_i = 12'sd1234; nco_sin_i = -12'sd777;
        s_ei = 16'sd0; s_eq = 16'sd0; chk_from = 1;
        release_rst(8);
        repeat (48) step(1'b1);
        drain("drain_offset_zero");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
